// File: rtl/i2c_seg_write_master.sv
// Single-byte I2C write initiator: START, addr+W, ACK, data, ACK, STOP.
// Open-drain style outputs: *_oe=1 pulls the line low.
module i2c_seg_write_master #(
  parameter int unsigned CLK_DIV = 25
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [6:0] dev_addr,
  input  logic [7:0] wr_data,
  input  logic       sda_in,
  output logic       scl_oe,
  output logic       sda_oe,
  output logic       busy,
  output logic       done,
  output logic       ack_err
);

  typedef enum logic [2:0] {IDLE, START, ADDR, ACK1, DATA, ACK2, STOP} state_t;

  localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);

  state_t      state, state_n;
  logic [1:0]  qtr, qtr_n;
  logic [15:0] div, div_n;
  logic [2:0]  bitcnt, bitcnt_n;
  logic [7:0]  shreg, shreg_n, data_q, data_n;
  logic        ack_err_n, done_n, sda_q;
  logic        tick;

  assign tick = (div == DIV_LAST);
  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      qtr     <= '0;
      div     <= '0;
      bitcnt  <= '0;
      shreg   <= '0;
      data_q  <= '0;
      ack_err <= 1'b0;
      done    <= 1'b0;
      sda_q   <= 1'b0;
    end else begin
      state   <= state_n;
      qtr     <= qtr_n;
      div     <= div_n;
      bitcnt  <= bitcnt_n;
      shreg   <= shreg_n;
      data_q  <= data_n;
      ack_err <= ack_err_n;
      done    <= done_n;
      sda_q   <= sda_oe;
    end
  end

  always_comb begin
    state_n   = state;
    qtr_n     = qtr;
    div_n     = div;
    bitcnt_n  = bitcnt;
    shreg_n   = shreg;
    data_n    = data_q;
    ack_err_n = ack_err;
    done_n    = 1'b0;
    if (state == IDLE) begin
      if (start) begin
        state_n   = START;
        qtr_n     = '0;
        div_n     = '0;
        bitcnt_n  = '0;
        shreg_n   = {dev_addr, 1'b0};
        data_n    = wr_data;
        ack_err_n = 1'b0;
      end
    end else if (!tick) begin
      div_n = div + 16'd1;
    end else begin
      div_n = '0;
      qtr_n = qtr + 2'd1;
      // ACK is sampled at the end of q2; the q3 decision below sees the updated flag
      if ((state == ACK1 || state == ACK2) && qtr == 2'd2)
        ack_err_n = ack_err | sda_in;
      if (qtr == 2'd3) begin
        case (state)
          START: begin
            state_n  = ADDR;
            bitcnt_n = '0;
          end
          ADDR, DATA: begin
            if (bitcnt == 3'd7) begin
              state_n = (state == ADDR) ? ACK1 : ACK2;
            end else begin
              bitcnt_n = bitcnt + 3'd1;
              shreg_n  = {shreg[6:0], 1'b0};
            end
          end
          ACK1: begin
            if (ack_err) begin
              state_n = STOP;
            end else begin
              state_n  = DATA;
              shreg_n  = data_q;
              bitcnt_n = '0;
            end
          end
          ACK2: state_n = STOP;
          STOP: begin
            state_n = IDLE;
            done_n  = 1'b1;
          end
          default: state_n = IDLE;
        endcase
      end
    end
  end

  // q0 of every SCL-low slot holds SDA so it only moves while SCL is already low
  always_comb begin
    scl_oe = 1'b0;
    sda_oe = 1'b0;
    case (state)
      START: begin
        scl_oe = (qtr == 2'd3);
        sda_oe = (qtr != 2'd0);
      end
      ADDR, DATA: begin
        scl_oe = (qtr < 2'd2);
        sda_oe = (qtr == 2'd0) ? sda_q : ~shreg[7];
      end
      ACK1, ACK2: begin
        scl_oe = (qtr < 2'd2);
        sda_oe = (qtr == 2'd0) ? sda_q : 1'b0;
      end
      STOP: begin
        scl_oe = (qtr < 2'd2);
        sda_oe = (qtr == 2'd0) ? sda_q : (qtr != 2'd3);
      end
      default: begin
        scl_oe = 1'b0;
        sda_oe = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_i2c_seg_write_master.sv
// Directed bench for i2c_seg_write_master with a behavioural segment-display target on the bus.
module tb_i2c_seg_write_master;

  localparam int unsigned DIV = 2;
  localparam logic [6:0] TGT_ADDR = 7'h3C;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [6:0] dev_addr = '0;
  logic [7:0] wr_data = '0;
  logic       sda_in;
  logic       scl_oe, sda_oe, busy, done, ack_err;

  int compared = 0;
  int mismatched = 0;

  i2c_seg_write_master #(.CLK_DIV(DIV)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .dev_addr (dev_addr),
    .wr_data  (wr_data),
    .sda_in   (sda_in),
    .scl_oe   (scl_oe),
    .sda_oe   (sda_oe),
    .busy     (busy),
    .done     (done),
    .ack_err  (ack_err)
  );

  always #5 clk = ~clk;

  // Open-drain bus and target model
  logic       tgt_pull = 1'b0;
  logic       ack_data = 1'b1;
  logic       addressed = 1'b0;
  logic       scl_p = 1'b1, sda_p = 1'b1;
  logic       scl_bus, sda_bus;
  logic       rec [32];
  int         nbits = 0, starts = 0, stops = 0;
  logic [7:0] seg = '0;
  logic [7:0] addr_byte, data_byte;

  assign scl_bus = ~scl_oe;
  assign sda_bus = ~(sda_oe | tgt_pull);
  assign sda_in  = sda_bus;

  always_comb begin
    addr_byte = '0;
    data_byte = '0;
    for (int i = 0; i < 8; i++) begin
      addr_byte[7-i] = rec[i];
      data_byte[7-i] = rec[9+i];
    end
  end

  always @(negedge clk) begin
    if (scl_p && scl_bus && sda_p && !sda_bus) begin
      starts    <= starts + 1;
      nbits     <= 0;
      addressed <= 1'b0;
    end
    if (scl_p && scl_bus && !sda_p && sda_bus)
      stops <= stops + 1;
    if (!scl_p && scl_bus && nbits < 32) begin
      rec[nbits] <= sda_bus;
      nbits      <= nbits + 1;
    end
    if (scl_p && !scl_bus) begin
      tgt_pull <= 1'b0;
      if (nbits == 8 && addr_byte[7:1] == TGT_ADDR && !addr_byte[0]) begin
        addressed <= 1'b1;
        tgt_pull  <= 1'b1;
      end
      if (nbits == 17 && addressed) begin
        tgt_pull <= ack_data;
        if (ack_data) seg <= data_byte;
      end
    end
    scl_p <= scl_bus;
    sda_p <= sda_bus;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic accept(input logic [6:0] a, input logic [7:0] d);
    @(negedge clk);
    dev_addr = a;
    wr_data  = d;
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(output int n);
    for (n = 1; n <= 400; n++) begin
      @(posedge clk);
      #1;
      if (done) break;
    end
  endtask

  int n, s0, p0, dones, ndone;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs", {27'd0, scl_oe, sda_oe, busy, done, ack_err}, 32'd0);
    @(negedge clk) rst = 1'b0;

    // Full write, target ACKs both bytes
    s0 = starts; p0 = stops;
    accept(7'h3C, 8'hA5);
    chk("t1_busy", busy, 1);
    wait_done(n);
    chk("t1_done_cycle", n, 160);
    chk("t1_busy_at_done", busy, 0);
    chk("t1_ack_err", ack_err, 0);
    chk("t1_addr_byte", addr_byte, 8'h78);
    chk("t1_ack1", rec[8], 0);
    chk("t1_data_byte", data_byte, 8'hA5);
    chk("t1_ack2", rec[17], 0);
    chk("t1_nbits", nbits, 19);
    chk("t1_starts", starts - s0, 1);
    chk("t1_stops", stops - p0, 1);
    chk("t1_seg", seg, 8'hA5);
    @(posedge clk); #1;
    chk("t1_done_one_cycle", done, 0);

    // Address with no target: NACK, straight to STOP
    s0 = starts; p0 = stops;
    accept(7'h21, 8'h55);
    wait_done(n);
    chk("t2_done_cycle", n, 88);
    chk("t2_ack_err", ack_err, 1);
    chk("t2_addr_byte", addr_byte, 8'h42);
    chk("t2_nbits", nbits, 10);
    chk("t2_stops", stops - p0, 1);
    repeat (3) @(posedge clk); #1;
    chk("t2_ack_err_hold", ack_err, 1);

    // Data NACK: full length, error flagged
    ack_data = 1'b0;
    accept(7'h3C, 8'hFF);
    chk("t3_ack_err_cleared_on_accept", ack_err, 0);
    wait_done(n);
    chk("t3_done_cycle", n, 160);
    chk("t3_ack_err", ack_err, 1);
    chk("t3_data_byte", data_byte, 8'hFF);
    chk("t3_ack2_nack", rec[17], 1);
    ack_data = 1'b1;

    // Starts while busy are ignored; latched operands unaffected
    accept(7'h3C, 8'h12);
    dones = 0; ndone = 0;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      start    = (k == 10 || k == 100);
      dev_addr = 7'h55;
      wr_data  = 8'hEE;
      @(posedge clk);
      #1;
      if (done) begin
        dones++;
        if (ndone == 0) ndone = k;
      end
    end
    start = 1'b0;
    chk("t4_done_count", dones, 1);
    chk("t4_done_cycle", ndone, 160);
    chk("t4_addr_byte", addr_byte, 8'h78);
    chk("t4_data_byte", data_byte, 8'h12);
    chk("t4_idle", busy, 0);

    // Reset mid-ADDR releases the bus without STOP
    p0 = stops;
    accept(7'h3C, 8'h99);
    repeat (49) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    chk("t5_rst_outs", {29'd0, scl_oe, sda_oe, busy}, 32'd0);
    @(negedge clk) rst = 1'b0;
    chk("t5_no_stop", stops - p0, 0);

    // Clean transaction after reset doubles as segment-display loopback
    s0 = starts; p0 = stops;
    accept(7'h3C, 8'h3F);
    wait_done(n);
    chk("t6_done_cycle", n, 160);
    chk("t6_ack_err", ack_err, 0);
    chk("t6_ack1", rec[8], 0);
    chk("t6_ack2", rec[17], 0);
    chk("t6_starts", starts - s0, 1);
    chk("t6_stops", stops - p0, 1);
    chk("t6_seg", seg, 8'h3F);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
